// File: rtl/enc_seq_priority.sv
// enc_seq_priority: sequential priority encoder.
// Captures a 2**CODE_W-bit request vector on a valid/ready handshake and
// emits the binary index of every set bit, one beat per bit, lowest first.
// An all-zero vector produces one beat with out_zero=1.
// Optional feature macro: ENC_PARITY_EN adds out_parity = ^out_code.
module enc_seq_priority #(
    parameter int CODE_W = 2,
    parameter int IN_W   = 2**CODE_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] out_code,
    output logic              out_last,
    output logic              out_zero
`ifdef ENC_PARITY_EN
    ,
    output logic              out_parity
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    localparam logic [IN_W-1:0] ONE = {{(IN_W-1){1'b0}}, 1'b1};

    state_t            state;
    logic [IN_W-1:0]   pending;
    logic              zero_flag;
    logic [CODE_W-1:0] lsb_idx;
    logic [IN_W-1:0]   pending_clr;
    logic              one_hot;
    logic              last_beat;
    logic              xfer;

    // Index of the lowest set bit of pending; scanning downward lets the
    // lowest hit overwrite any higher one.
    always_comb begin
        lsb_idx = '0;
        for (int i = IN_W - 1; i >= 0; i--) begin
            if (pending[i]) lsb_idx = CODE_W'(i);
        end
    end

    // Beat bookkeeping: clearing the lowest set bit, and detecting the final
    // beat (a single remaining bit, or the lone beat of an empty vector).
    always_comb begin
        pending_clr = pending & (pending - ONE);
        one_hot     = (pending != '0) && (pending_clr == '0);
        last_beat   = one_hot || zero_flag;
        xfer        = out_valid && out_ready;
    end

    // Control FSM; handshake flags are registered alongside the state so that
    // reset forces them immediately and they never glitch mid-cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pending   <= '0;
            zero_flag <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        pending   <= in_data;
                        zero_flag <= (in_data == '0);
                        state     <= EMIT;
                        in_ready  <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end
                EMIT: begin
                    // in_valid/in_data are deliberately not looked at here.
                    if (xfer) begin
                        pending <= pending_clr;
                        if (last_beat) begin
                            state     <= IDLE;
                            zero_flag <= 1'b0;
                            in_ready  <= 1'b1;
                            out_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Beat payload, forced to zero whenever no beat is presented; an empty
    // vector reports code 0.
    always_comb begin
        out_code = '0;
        out_last = 1'b0;
        out_zero = 1'b0;
        if (out_valid) begin
            out_code = zero_flag ? '0 : lsb_idx;
            out_last = last_beat;
            out_zero = zero_flag;
        end
    end

`ifdef ENC_PARITY_EN
    // Parity follows out_code exactly, including being 0 when no beat is valid.
    always_comb begin
        out_parity = ^out_code;
    end
`endif

endmodule

// File: tb/tb_enc_seq_priority.sv
// Self-checking bench for enc_seq_priority (CODE_W=2).
// Table-driven vectors, hand-written multi-cycle corner cases, and random
// vectors checked against a bit-list reference model.
module tb_enc_seq_priority;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_code;
    logic       out_last;
    logic       out_zero;
`ifdef ENC_PARITY_EN
    logic       out_parity;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    enc_seq_priority #(.CODE_W(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_code   (out_code),
        .out_last   (out_last),
        .out_zero   (out_zero)
`ifdef ENC_PARITY_EN
        ,
        .out_parity (out_parity)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] data;
        int         n;
        logic [1:0] codes [4];
        logic       zero;
    } vec_t;

    logic [1:0] exp_q[$];
    logic       exp_zero;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: list of set-bit indices, lowest first; empty vector -> one code-0 beat.
    task automatic model(input logic [3:0] d);
        exp_q.delete();
        for (int i = 0; i < 4; i++)
            if (((d >> i) & 4'd1) != 0) exp_q.push_back(2'(i));
        exp_zero = (d == 4'd0);
        if (exp_zero) exp_q.push_back(2'd0);
    endtask

    // Present one vector and check every beat against exp_q/exp_zero.
    // stall_first: out_ready low cycles before beat 0; rnd: random stalls later.
    task automatic run_vec(input logic [3:0] d, input int stall_first, input bit rnd);
        int stall;
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = d;
        out_ready = 1'b0;
        chk("in_ready_idle", in_ready, 1);
        chk("out_valid_idle", out_valid, 0);
        chk("out_code_idle", out_code, 0);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 4'($urandom);
        for (int b = 0; b < exp_q.size(); b++) begin
            stall = (b == 0) ? stall_first : (rnd ? int'($urandom_range(0, 2)) : 0);
            out_ready = 1'b0;
            for (int s = 0; s < stall; s++) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_code", out_code, exp_q[b]);
                chk("hold_last", out_last, (b == exp_q.size() - 1));
                chk("hold_in_ready", in_ready, 0);
                @(negedge clk);
            end
            out_ready = 1'b1;
            chk("beat_valid", out_valid, 1);
            chk("beat_code", out_code, exp_q[b]);
            chk("beat_last", out_last, (b == exp_q.size() - 1));
            chk("beat_zero", out_zero, exp_zero);
`ifdef ENC_PARITY_EN
            chk("beat_parity", out_parity, ^exp_q[b]);
`endif
            @(negedge clk);
        end
        chk("done_valid", out_valid, 0);
        chk("done_in_ready", in_ready, 1);
        out_ready = 1'b1;
    endtask

    vec_t tbl[5];

    initial begin
        tbl[0] = '{data: 4'b1010, n: 2, codes: '{2'd1, 2'd3, 2'd0, 2'd0}, zero: 1'b0};
        tbl[1] = '{data: 4'b0000, n: 1, codes: '{2'd0, 2'd0, 2'd0, 2'd0}, zero: 1'b1};
        tbl[2] = '{data: 4'b1111, n: 4, codes: '{2'd0, 2'd1, 2'd2, 2'd3}, zero: 1'b0};
        tbl[3] = '{data: 4'b1000, n: 1, codes: '{2'd3, 2'd0, 2'd0, 2'd0}, zero: 1'b0};
        tbl[4] = '{data: 4'b0110, n: 2, codes: '{2'd1, 2'd2, 2'd0, 2'd0}, zero: 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 4'd0;
        out_ready = 1'b1;
        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_code", out_code, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_zero", out_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table vectors (1010 and 0000 cover basic and empty cases).
        for (int t = 0; t < 5; t++) begin
            exp_q.delete();
            for (int k = 0; k < tbl[t].n; k++) exp_q.push_back(tbl[t].codes[k]);
            exp_zero = tbl[t].zero;
            run_vec(tbl[t].data, 0, 1'b0);
        end

        // Backpressure: 1111 with out_ready low for 3 cycles before the first beat.
        exp_q = '{2'd0, 2'd1, 2'd2, 2'd3};
        exp_zero = 1'b0;
        run_vec(4'b1111, 3, 1'b0);

        // Reset mid-operation: 0110, reset after the code-1 beat transfers.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 4'b0110;
        @(negedge clk);
        in_valid = 1'b0;
        chk("rm_code1", out_code, 1);
        @(negedge clk);
        chk("rm_code2_shown", out_code, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("rm_async_valid", out_valid, 0);
        chk("rm_async_in_ready", in_ready, 1);
        chk("rm_async_code", out_code, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rm_no_beat", out_valid, 0);
            chk("rm_in_ready", in_ready, 1);
        end

        // Ignored input: 0001 accepted with out_ready=0, then an in_valid pulse of 1000.
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 4'b0001;
        @(negedge clk);
        in_data = 4'b1000;
        chk("ig_in_ready", in_ready, 0);
        chk("ig_code", out_code, 0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("ig_hold_code", out_code, 0);
        chk("ig_hold_last", out_last, 1);
        out_ready = 1'b1;
        @(negedge clk);
        chk("ig_done_valid", out_valid, 0);
        chk("ig_done_in_ready", in_ready, 1);
        @(negedge clk);
        chk("ig_not_taken", out_valid, 0);
        model(4'b1000);
        run_vec(4'b1000, 0, 1'b0);

`ifdef ENC_PARITY_EN
        model(4'b1010);
        run_vec(4'b1010, 1, 1'b0);
`endif

        // Random vectors with random backpressure against the reference model.
        for (int r = 0; r < 60; r++) begin
            logic [3:0] d;
            d = 4'($urandom);
            model(d);
            run_vec(d, int'($urandom_range(0, 2)), 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
